// File: rtl/alu_mdu_controller.sv
// ALU operation decode plus an iterative RV32M multiply/divide sequencer.
// Define MDU_DIV_EN to build the divider; without it, divide ops raise md_illegal_o.
module alu_mdu_controller #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            rtype_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      Operation,
  output logic            md_sel_o,
  output logic [XLEN-1:0] md_result_o,
  output logic            stall_o,
  output logic            md_illegal_o
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*XLEN-1:0]  acc, acc_nxt, prod;
  logic [XLEN-1:0]    opb, mag_a, mag_b, mul_res;
  logic [1:0]         f3_q;
  logic               neg_q, sa, sb, mop, accept, launch;

  // One shift-add multiply step: acc = {partial product, remaining multiplier}.
  function automatic logic [2*XLEN-1:0] mul_bit(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0]   m);
    logic [XLEN:0] s;
    s = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    return {s, p[XLEN-1:1]};
  endfunction

`ifdef MDU_DIV_EN
  logic            neg_r, div_zero, div_ovf;
  logic [XLEN-1:0] quo, rem, div_res, div_special;

  // One restoring-division step: acc = {remainder, dividend/quotient}.
  function automatic logic [2*XLEN-1:0] div_bit(input logic [2*XLEN-1:0] r,
                                                 input logic [XLEN-1:0]   d);
    logic [XLEN:0] sh, t;
    sh = r[2*XLEN-1:XLEN-1];
    t  = sh - {1'b0, d};
    if (!t[XLEN]) return {t[XLEN-1:0], r[XLEN-2:0], 1'b1};
    else          return {sh[XLEN-1:0], r[XLEN-2:0], 1'b0};
  endfunction

  assign div_zero    = (rs2_i == '0);
  assign div_ovf     = ~Funct3[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
  assign div_special = div_zero ? (Funct3[1] ? rs1_i : '1)
                                : (Funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  assign quo         = acc_nxt[XLEN-1:0];
  assign rem         = acc_nxt[2*XLEN-1:XLEN];
  assign div_res     = f3_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
`endif

  assign mop    = valid_i & rtype_i & (ALUOp == 2'b10) & (Funct7 == 7'b0000001);
  assign accept = rst_n & (state == IDLE) & mop & ~flush_i;

`ifdef MDU_DIV_EN
  assign launch       = accept;
  assign md_illegal_o = 1'b0;
`else
  assign launch       = accept & ~Funct3[2];
  assign md_illegal_o = accept & Funct3[2];
`endif

  assign stall_o  = launch | (rst_n & ~flush_i & ((state == MUL) | (state == DIV)));
  assign md_sel_o = rst_n & ~flush_i & (state == DONE);

  always_comb begin
    Operation = 4'b0000;
    if (mop) begin
      Operation = 4'b0010;
    end else begin
      case (ALUOp)
        2'b00: Operation = 4'b0010;
        2'b01: case (Funct3)
                 3'b000:  Operation = 4'b1001;
                 3'b001:  Operation = 4'b1010;
                 3'b100:  Operation = 4'b1000;
                 3'b101:  Operation = 4'b1011;
                 default: Operation = 4'b0000;
               endcase
        2'b10: case (Funct3)
                 3'b000:  Operation = (rtype_i && Funct7 == 7'b0100000) ? 4'b0011 : 4'b0010;
                 3'b001:  Operation = 4'b0111;
                 3'b010:  Operation = 4'b1000;
                 3'b100:  Operation = 4'b0100;
                 3'b101:  Operation = (Funct7 == 7'b0100000) ? 4'b0110 : 4'b0101;
                 3'b110:  Operation = 4'b0001;
                 default: Operation = 4'b0000;
               endcase
        default: Operation = 4'b1111;
      endcase
    end
  end

  // Iterate on magnitudes; signs are reapplied once the result is final.
  always_comb begin
    if (Funct3[2]) begin
      sa = ~Funct3[0] & rs1_i[XLEN-1];
      sb = ~Funct3[0] & rs2_i[XLEN-1];
    end else begin
      sa = ((Funct3[1:0] == 2'b01) | (Funct3[1:0] == 2'b10)) & rs1_i[XLEN-1];
      sb = (Funct3[1:0] == 2'b01) & rs2_i[XLEN-1];
    end
    mag_a = sa ? -rs1_i : rs1_i;
    mag_b = sb ? -rs2_i : rs2_i;
  end

  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < UNROLL; i++) begin
`ifdef MDU_DIV_EN
      if (state == DIV) acc_nxt = div_bit(acc_nxt, opb);
      else              acc_nxt = mul_bit(acc_nxt, opb);
`else
      acc_nxt = mul_bit(acc_nxt, opb);
`endif
    end
    prod    = neg_q ? -acc_nxt : acc_nxt;
    mul_res = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      md_result_o <= '0;
`ifdef MDU_DIV_EN
      neg_r       <= 1'b0;
`endif
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (launch) begin
          f3_q  <= Funct3[1:0];
          opb   <= mag_b;
          acc   <= {{XLEN{1'b0}}, mag_a};
          cnt   <= CW'(N);
          neg_q <= sa ^ sb;
          state <= MUL;
`ifdef MDU_DIV_EN
          neg_r <= sa;
          if (Funct3[2]) begin
            if (div_zero | div_ovf) begin
              md_result_o <= div_special;
              state       <= DONE;
            end else begin
              state <= DIV;
            end
          end
`endif
        end
        MUL, DIV: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
`ifdef MDU_DIV_EN
            md_result_o <= (state == DIV) ? div_res : mul_res;
`else
            md_result_o <= mul_res;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu_controller.sv
// Directed bench for alu_mdu_controller: expected results go into a scoreboard
// queue and a negedge monitor checks them whenever md_sel_o is presented.
module tb_alu_mdu_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, rtype_i = 1'b0, flush_i = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic [6:0]  Funct7 = 7'b0;
  logic [2:0]  Funct3 = 3'b0;
  logic [31:0] rs1_i = 32'h0, rs2_i = 32'h0;
  logic [3:0]  Operation;
  logic        md_sel_o, stall_o, md_illegal_o;
  logic [31:0] md_result_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    int          id;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  alu_mdu_controller #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .rtype_i(rtype_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .Operation(Operation), .md_sel_o(md_sel_o), .md_result_o(md_result_o),
    .stall_o(stall_o), .md_illegal_o(md_illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && md_sel_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_md_sel actual=0x%08h required=no_result", md_result_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("md_result_%0d", mon_e.id), md_result_o, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; rtype_i = 1'b0; flush_i = 1'b0;
    ALUOp = 2'b00; Funct7 = 7'b0; Funct3 = 3'b0;
  endtask

  task automatic set_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; rtype_i = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001;
    Funct3 = f3; rs1_i = a; rs2_i = b;
  endtask

  // Counts stall cycles up to the first non-stalled cycle, which must be DONE.
  task automatic wait_done(input string name, input int exp_stall);
    int n;
    n = 0;
    @(negedge clk);
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({name, "_md_sel"}, 32'(md_sel_o), 32'd1);
    step();
    idle_inputs();
  endtask

  task automatic run_mop(input string name, input int id, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall);
    exp_t e;
    step();
    set_mop(f3, a, b);
    e.data = exp;
    e.id   = id;
    sb_q.push_back(e);
    wait_done(name, exp_stall);
  endtask

  task automatic dec(input string name, input logic [1:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic rt, input logic [3:0] exp);
    valid_i = 1'b1; ALUOp = op; Funct3 = f3; Funct7 = f7; rtype_i = rt;
    #1;
    chk({name, "_op"}, 32'(Operation), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // Reset with a divide and then a multiply presented at the inputs.
    set_mop(3'b100, 32'd10, 32'd2);
    #2;
    chk("rst_illegal", 32'(md_illegal_o), 32'd0);
    set_mop(3'b000, 32'd7, 32'hFFFF_FFFD);
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_md_sel", 32'(md_sel_o), 32'd0);
    chk("rst_result", md_result_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    e.data = 32'hFFFF_FFEB; e.id = 1;
    sb_q.push_back(e);
    wait_done("mul_first", 33);

    @(negedge clk);
    chk("hold_result", md_result_o, 32'hFFFF_FFEB);
    chk("hold_md_sel", 32'(md_sel_o), 32'd0);

    dec("sub", 2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0011);
    chk("sub_stall", 32'(stall_o), 32'd0);
    dec("bge", 2'b01, 3'b101, 7'b0000000, 1'b0, 4'b1011);
    dec("add", 2'b10, 3'b000, 7'b0000000, 1'b1, 4'b0010);
    dec("addi_hi", 2'b10, 3'b000, 7'b0100000, 1'b0, 4'b0010);
    dec("addi_m7", 2'b10, 3'b000, 7'b0000001, 1'b0, 4'b0010);
    chk("addi_m7_stall", 32'(stall_o), 32'd0);
    dec("sra", 2'b10, 3'b101, 7'b0100000, 1'b1, 4'b0110);
    dec("srl", 2'b10, 3'b101, 7'b0000000, 1'b1, 4'b0101);
    dec("xor", 2'b10, 3'b100, 7'b0000000, 1'b1, 4'b0100);
    dec("sll", 2'b10, 3'b001, 7'b0000000, 1'b1, 4'b0111);
    dec("or", 2'b10, 3'b110, 7'b0000000, 1'b1, 4'b0001);
    dec("slt", 2'b10, 3'b010, 7'b0000000, 1'b1, 4'b1000);
    dec("beq", 2'b01, 3'b000, 7'b0000000, 1'b0, 4'b1001);
    dec("bne", 2'b01, 3'b001, 7'b0000000, 1'b0, 4'b1010);
    dec("blt", 2'b01, 3'b100, 7'b0000000, 1'b0, 4'b1000);
    dec("br_undef", 2'b01, 3'b010, 7'b0000000, 1'b0, 4'b0000);
    dec("lw", 2'b00, 3'b010, 7'b0000000, 1'b0, 4'b0010);
    dec("jal", 2'b11, 3'b000, 7'b0000000, 1'b0, 4'b1111);
    idle_inputs();

    run_mop("mulh", 2, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_mop("mulhu", 3, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_mop("mulhsu", 4, 3'b010, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 33);
    run_mop("mulhsu_neg", 5, 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
    run_mop("mul_lo", 6, 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);

`ifdef MDU_DIV_EN
    run_mop("divu_zero", 10, 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_mop("rem_zero", 11, 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
    run_mop("div_ovf", 12, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_mop("rem_ovf", 13, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_mop("rem_neg", 14, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mop("div_neg", 15, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mop("remu", 16, 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_mop("divu", 17, 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);

    // Flush a divide on its tenth iteration; it must produce no result.
    step();
    set_mop(3'b100, 32'd1000, 32'd3);
    @(negedge clk);
    chk("div_launch_op", 32'(Operation), 32'b0010);
    chk("div_launch_illegal", 32'(md_illegal_o), 32'd0);
    for (int k = 0; k < 10; k++) step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_md_sel", 32'(md_sel_o), 32'd0);
    step();
    flush_i = 1'b0;
    set_mop(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e.data = 32'hFFFF_FFFE; e.id = 18;
    sb_q.push_back(e);
    wait_done("mulhu_after_flush", 33);
`else
    step();
    set_mop(3'b100, 32'd10, 32'd2);
    @(negedge clk);
    chk("div_illegal", 32'(md_illegal_o), 32'd1);
    chk("div_illegal_stall", 32'(stall_o), 32'd0);
    chk("div_illegal_md_sel", 32'(md_sel_o), 32'd0);
    chk("div_illegal_op", 32'(Operation), 32'b0010);
    step();
    idle_inputs();
    @(negedge clk);
    chk("illegal_clear", 32'(md_illegal_o), 32'd0);
    run_mop("mul_3x4", 20, 3'b000, 32'd3, 32'd4, 32'd12, 33);
`endif

    // Reset during MUL iteration 5, then relaunch straight after release.
    step();
    set_mop(3'b000, 32'd5, 32'd6);
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_md_sel", 32'(md_sel_o), 32'd0);
    chk("midrst_result", md_result_o, 32'h0);
    chk("midrst_illegal", 32'(md_illegal_o), 32'd0);
    #1;
    rst_n = 1'b1;
    e.data = 32'd30; e.id = 30;
    sb_q.push_back(e);
    wait_done("mul_after_reset", 33);

    repeat (3) step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mdu_controller.md
ALU_MDU_CONTROLLER -- requirements
Module: alu_mdu_controller

Interface
REQ-001 XLEN, 32, datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 UNROLL, 1, multiply/divide bits processed per iteration cycle; SHALL divide XLEN.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 valid_i  in  1  instruction in EX is valid.
REQ-006 rtype_i  in  1  instruction is register-register (Funct7 meaningful).
REQ-007 flush_i  in  1  abort the current instruction.
REQ-008 ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-009 Funct7  in  7  instruction bits 31:25.
REQ-010 Funct3  in  3  instruction bits 14:12.
REQ-011 rs1_i, rs2_i  in  XLEN each  operands.
REQ-012 Operation  out  4  ALU operation select.
REQ-013 md_sel_o  out  1  writeback SHALL take md_result_o this cycle.
REQ-014 md_result_o  out  XLEN  multiply/divide result.
REQ-015 stall_o  out  1  freeze the pipeline; EX inputs held stable while high.
REQ-016 md_illegal_o  out  1  division requested but not built.

Function
REQ-017 Operation SHALL be combinational: AND 0000, OR 0001, ADD/LW/SW/AUIPC 0010, SUB 0011, XOR 0100, SRL 0101, SRA 0110, SLL 0111, SLT/BLT 1000, BEQ 1001, BNE 1010, BGE 1011, JAL/LUI 1111; undecoded combinations 0000.
REQ-018 M-op = valid_i & rtype_i & ALUOp==10 & Funct7==0000001; during an M-op Operation SHALL be 0010.
REQ-019 FSM states IDLE, MUL, DIV, DONE; N = XLEN/UNROLL.
REQ-020 IDLE: on M-op with Funct3 0-3, latch operands, load counter N, go MUL; on Funct3 4-7, go DIV; otherwise stay IDLE.
REQ-021 MUL/DIV: counter decrements each cycle; on counter reaching 0, go DONE.
REQ-022 DONE: md_sel_o=1, md_result_o valid, stall_o=0; next state IDLE unconditionally, so the held instruction is not relaunched.
REQ-023 stall_o SHALL be 1 combinationally in the accept cycle and in every MUL/DIV cycle: N+1 cycles total for an iterative op.
REQ-024 MUL low XLEN bits; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, upper XLEN bits of the 2*XLEN product.
REQ-025 DIV/REM signed, truncating toward zero, remainder takes the dividend's sign; DIVU/REMU unsigned.
REQ-026 Divide by zero: quotient all ones, remainder = rs1; resolved in the accept cycle, straight to DONE (stall 1 cycle).
REQ-027 Signed overflow (most-negative / -1): quotient = most-negative, remainder 0; straight to DONE (stall 1 cycle).
REQ-028 flush_i SHALL take priority in every state: stall_o=0 that cycle, no md_sel_o, next state IDLE; a flushed op produces no result.
REQ-029 valid_i=0 in IDLE SHALL launch nothing; valid_i is ignored outside IDLE.
REQ-030 md_result_o SHALL hold its last value outside DONE; md_sel_o=0 outside DONE.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counter 0, operand/accumulator registers 0, md_result_o 0, md_sel_o 0, stall_o 0, md_illegal_o 0, aborting any op in flight.
REQ-032 After rst_n rises, the first edge SHALL already accept an M-op.

Configuration
REQ-033 Macro MDU_DIV_EN defined: divider built; md_illegal_o tied 0.
REQ-034 MDU_DIV_EN undefined: no divider logic; M-op Funct3 4-7 SHALL stay IDLE, stall_o=0, md_sel_o=0, md_illegal_o=1 combinationally for that cycle; multiply unaffected.

Verification (XLEN=32, UNROLL=1)
REQ-035 ALUOp=10, Funct3=000, Funct7=0100000, rtype_i=1 -> Operation=0011, stall_o=0; ALUOp=01, Funct3=101 -> 1011.
REQ-036 MUL 7 x 0xFFFFFFFD -> stall_o high 33 cycles, then DONE with md_result_o=0xFFFFFFEB, md_sel_o=1; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-037 DIVU 100/0 -> 1 stall cycle, result 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 1 stall cycle, result 0x80000000; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF after 33 stall cycles.
REQ-038 DIV launched, flush_i=1 on iteration 10 -> stall_o=0 that cycle, IDLE next cycle, no md_sel_o; following MULU accepted one cycle later, completes normally.
REQ-039 rst_n low mid-MUL iteration 5 -> stall_o=0 immediately, all outputs reset; next M-op after release runs full 33 cycles.
REQ-040 Build without MDU_DIV_EN: DIV 10/2 -> md_illegal_o=1 one cycle, stall_o=0, md_sel_o=0; MUL 3 x 4 -> 12.
